// File: rtl/led_trail_pwm_if.sv
// Bundles the pattern/control inputs and the LED/brightness outputs of led_trail_pwm.
// master = pattern generator / board side, slave = the PWM output stage.
interface led_trail_pwm_if #(
  parameter int WIDTH      = 16,
  parameter int LEVEL_BITS = 4
);
  logic [WIDTH-1:0]      pattern_in;
  logic                  enable;
  logic                  bright_up;
  logic                  bright_dn;
  logic [WIDTH-1:0]      led_out;
  logic [LEVEL_BITS-1:0] bright_level;

  modport master (
    output pattern_in, enable, bright_up, bright_dn,
    input  led_out, bright_level
  );

  modport slave (
    input  pattern_in, enable, bright_up, bright_dn,
    output led_out, bright_level
  );
endinterface

// File: rtl/led_trail_pwm.sv
// LED output stage: each lit pattern bit holds its channel at full level, then it fades
// one step per decay tick; per-channel PWM duty is scaled by a global brightness.
module led_trail_pwm #(
  parameter int WIDTH      = 16,
  parameter int LEVEL_BITS = 4,
  parameter int PWM_DIV    = 64,
  parameter int DECAY_DIV  = 1250000
) (
  input  logic            clk,
  input  logic            rstn,
  led_trail_pwm_if.slave  bus
);

  localparam int PW    = (PWM_DIV   > 1) ? $clog2(PWM_DIV)   : 1;
  localparam int DW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int PRODW = 2 * LEVEL_BITS + 1;
  localparam int DUTYW = LEVEL_BITS + 1;

  localparam logic [LEVEL_BITS-1:0] MAX       = '1;
  localparam logic [PW-1:0]         PCNT_LAST = PW'(PWM_DIV - 1);
  localparam logic [DW-1:0]         DCNT_LAST = DW'(DECAY_DIV - 1);

  logic [WIDTH-1:0]      r_pat_q;
  logic [DW-1:0]         r_dcnt;
  logic [PW-1:0]         r_pcnt;
  logic [LEVEL_BITS-1:0] r_pwm_cnt;
  logic [LEVEL_BITS-1:0] r_bright;
  logic [LEVEL_BITS-1:0] r_level [WIDTH];
  logic [WIDTH-1:0]      r_led_out;

  logic [LEVEL_BITS-1:0] w_level_next [WIDTH];
  logic [WIDTH-1:0]      w_led_next;
  logic                  w_decay_tick;
  logic                  w_pwm_step;
  logic [DUTYW-1:0]      w_bright_p1;
  logic                  w_up_only;
  logic                  w_dn_only;

  assign w_decay_tick = (r_dcnt == DCNT_LAST);
  assign w_pwm_step   = (r_pcnt == PCNT_LAST);
  assign w_bright_p1  = {1'b0, r_bright} + DUTYW'(1);
  assign w_up_only    = bus.bright_up & ~bus.bright_dn;
  assign w_dn_only    = bus.bright_dn & ~bus.bright_up;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [PRODW-1:0] w_prod;
      logic [DUTYW-1:0] w_duty;

      assign w_level_next[gi] = r_pat_q[gi] ? MAX :
                                (w_decay_tick && (r_level[gi] != '0)) ? r_level[gi] - 1'b1 :
                                r_level[gi];

      // Full-width product before the shift so bright=MAX gives duty == level exactly.
      assign w_prod         = PRODW'(r_level[gi]) * PRODW'(w_bright_p1);
      assign w_duty         = DUTYW'(w_prod >> LEVEL_BITS);
      assign w_led_next[gi] = bus.enable & ({1'b0, r_pwm_cnt} < w_duty);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pat_q   <= '0;
      r_dcnt    <= '0;
      r_pcnt    <= '0;
      r_pwm_cnt <= '0;
      r_bright  <= MAX;
      r_led_out <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_level[i] <= '0;
      end
    end else begin
      r_pat_q   <= bus.pattern_in;
      r_dcnt    <= w_decay_tick ? '0 : r_dcnt + 1'b1;
      r_pcnt    <= w_pwm_step   ? '0 : r_pcnt + 1'b1;
      if (w_pwm_step) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      if (w_up_only && (r_bright != MAX)) begin
        r_bright <= r_bright + 1'b1;
      end else if (w_dn_only && (r_bright != '0)) begin
        r_bright <= r_bright - 1'b1;
      end
      r_led_out <= w_led_next;
      for (int i = 0; i < WIDTH; i++) begin
        r_level[i] <= w_level_next[i];
      end
    end
  end

  assign bus.led_out      = r_led_out;
  assign bus.bright_level = r_bright;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm with small prescalers (PWM_DIV=2, DECAY_DIV=8);
// duty is measured by counting high cycles over whole 32-cycle PWM periods.
module tb_led_trail_pwm;

  logic clk;
  logic rstn;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt;
  int   other;

  led_trail_pwm_if #(.WIDTH(16), .LEVEL_BITS(4)) bus ();

  led_trail_pwm #(
    .WIDTH(16), .LEVEL_BITS(4), .PWM_DIV(2), .DECAY_DIV(8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
      $display("check %-22s obs=%0d exp=%0d ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts high cycles of one LED and ORs in any activity on the other LEDs.
  task automatic count_high(input int b, input int n, output int hi, output int rest);
    logic [15:0] mask;
    mask = 16'h0001 << b;
    hi   = 0;
    rest = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      hi = hi + int'(bus.led_out[b]);
      if ((bus.led_out & ~mask) != 16'h0000) rest = 1;
    end
  endtask

  task automatic pulse(input logic up, input logic dn);
    bus.bright_up = up;
    bus.bright_dn = dn;
    tick();
    bus.bright_up = 1'b0;
    bus.bright_dn = 1'b0;
    tick();
  endtask

  initial begin
    rstn           = 1'b0;
    bus.pattern_in = 16'h0000;
    bus.enable     = 1'b1;
    bus.bright_up  = 1'b0;
    bus.bright_dn  = 1'b0;

    // 1. reset
    tick(3);
    chk("reset_led", int'(bus.led_out), 0);
    chk("reset_bright", int'(bus.bright_level), 15);
    rstn = 1'b1;
    count_high(15, 64, cnt, other);
    chk("idle_led15", cnt, 0);
    chk("idle_others", other, 0);

    // 2. single LED at full level: 15/16 duty
    bus.pattern_in = 16'h8000;
    tick(4);
    count_high(15, 256, cnt, other);
    chk("full_led15_hi", cnt, 240);
    chk("full_others", other, 0);

    // 3. hand over to bit 14; bit 15 fades out
    bus.pattern_in = 16'h4000;
    tick(130);
    count_high(15, 64, cnt, other);
    chk("faded_led15", cnt, 0);
    count_high(14, 256, cnt, other);
    chk("held_led14_hi", cnt, 240);
    chk("held_others", other, 0);

    // 4. brightness down to 0, simultaneous pulses, one step up
    pulse(1'b0, 1'b1);
    chk("bright_dn1", int'(bus.bright_level), 14);
    for (int k = 0; k < 15; k++) pulse(1'b0, 1'b1);
    chk("bright_sat0", int'(bus.bright_level), 0);
    count_high(14, 64, cnt, other);
    chk("bright0_led14", cnt, 0);
    pulse(1'b1, 1'b1);
    chk("bright_both", int'(bus.bright_level), 0);
    pulse(1'b1, 1'b0);
    chk("bright_up1", int'(bus.bright_level), 1);
    tick(2);
    count_high(14, 256, cnt, other);
    chk("bright1_led14_hi", cnt, 16);

    // 5. enable off mid-fade, then resume
    for (int k = 0; k < 20; k++) pulse(1'b1, 1'b0);
    chk("bright_satF", int'(bus.bright_level), 15);
    bus.pattern_in = 16'h0000;
    tick(20);
    bus.enable = 1'b0;
    tick();
    chk("disable_next_edge", int'(bus.led_out), 0);
    count_high(14, 40, cnt, other);
    chk("disabled_led14", cnt, 0);
    bus.enable = 1'b1;
    count_high(14, 32, cnt, other);
    chk("resume_decayed", int'(cnt >= 2 && cnt <= 18), 1);
    tick(120);
    count_high(14, 32, cnt, other);
    chk("resume_to_zero", cnt, 0);

    // 6. reset mid-fade with 0x0101 on the input
    for (int k = 0; k < 10; k++) pulse(1'b0, 1'b1);
    chk("bright_5", int'(bus.bright_level), 5);
    bus.pattern_in = 16'h4000;
    tick(16);
    bus.pattern_in = 16'h0000;
    tick(12);
    bus.pattern_in = 16'h0101;
    rstn = 1'b0;
    tick();
    chk("midrst_led", int'(bus.led_out), 0);
    chk("midrst_bright", int'(bus.bright_level), 15);
    rstn = 1'b1;
    tick();
    chk("rel_plus1_led", int'(bus.led_out), 0);
    tick();
    chk("rel_plus2_led", int'(bus.led_out), 0);
    tick();
    chk("rel_plus3_led", int'(bus.led_out), 16'h0101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
